// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// Holds the FSM state encodings, datapath widths and the default bus timeout.
package mem_arbiter_pkg;

    localparam int unsigned DATA_W          = 16;
    localparam int unsigned CNT_W           = 8;
    localparam int unsigned TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        INST = 2'd2
    } arb_state_e;

    // True while a bus access is outstanding.
    function automatic logic is_busy(input arb_state_e st);
        return (st == DATA) || (st == INST);
    endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// Bus wait counter for the memory arbiter.
// It flags expiry on the wait cycle that brings the count up to LIMIT.
module mem_arb_timeout
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             count_en,
    output logic             expired,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 32'd1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear on grant, otherwise saturating increment while waiting.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = CNT_ZERO;
        end else if (count_en && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= CNT_ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = count_en && !clear && (count_q == CNT_LAST);
    assign count   = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the data stage.
// Data wins ties; an access in flight always runs to bus_ack or to the wait timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_ready,
    output logic        pipe_stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    input  logic [15:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_err
);

    arb_state_e  state_q;
    arb_state_e  state_d;
    logic        bus_req_q;
    logic        bus_req_d;
    logic        bus_we_q;
    logic        bus_we_d;
    logic [15:0] bus_addr_q;
    logic [15:0] bus_addr_d;
    logic [15:0] bus_wdata_q;
    logic [15:0] bus_wdata_d;
    logic [15:0] mem_rdata_q;
    logic [15:0] mem_rdata_d;
    logic [15:0] if_rdata_q;
    logic [15:0] if_rdata_d;
    logic        mem_ready_q;
    logic        mem_ready_d;
    logic        if_ready_q;
    logic        if_ready_d;
    logic        bus_err_q;
    logic        bus_err_d;

    logic             data_req_s;
    logic             cnt_clear_s;
    logic             cnt_en_s;
    logic             cnt_expired_s;
    logic [CNT_W-1:0] wait_cnt_unused;

    assign data_req_s = mem_read || mem_write;
    assign cnt_en_s   = is_busy(state_q) && !bus_ack;

    mem_arb_timeout #(
        .LIMIT    (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear_s),
        .count_en (cnt_en_s),
        .expired  (cnt_expired_s),
        .count    (wait_cnt_unused)
    );

    // Next-state and registered-output logic; a ready pulse blocks re-grant of its own request.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        mem_rdata_d = mem_rdata_q;
        if_rdata_d  = if_rdata_q;
        mem_ready_d = 1'b0;
        if_ready_d  = 1'b0;
        bus_err_d   = bus_err_q;
        cnt_clear_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (data_req_s && !mem_ready_q) begin
                    state_d     = DATA;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_write;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                    cnt_clear_s = 1'b1;
                end else if (if_req && !if_ready_q) begin
                    state_d     = INST;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = if_addr;
                    cnt_clear_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end

            DATA: begin
                if (bus_ack) begin
                    state_d     = IDLE;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    mem_ready_d = 1'b1;
                    if (!bus_we_q) begin
                        mem_rdata_d = bus_rdata;
                    end else begin
                        mem_rdata_d = mem_rdata_q;
                    end
                end else if (cnt_expired_s) begin
                    state_d     = IDLE;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    mem_ready_d = 1'b1;
                    bus_err_d   = 1'b1;
                    if (!bus_we_q) begin
                        mem_rdata_d = 16'h0000;
                    end else begin
                        mem_rdata_d = mem_rdata_q;
                    end
                end else begin
                    state_d = DATA;
                end
            end

            INST: begin
                if (bus_ack) begin
                    state_d    = IDLE;
                    bus_req_d  = 1'b0;
                    if_ready_d = 1'b1;
                    if_rdata_d = bus_rdata;
                end else if (cnt_expired_s) begin
                    state_d    = IDLE;
                    bus_req_d  = 1'b0;
                    if_ready_d = 1'b1;
                    if_rdata_d = 16'h0000;
                    bus_err_d  = 1'b1;
                end else begin
                    state_d = INST;
                end
            end

            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
                bus_we_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any access without a ready pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 16'h0000;
            bus_wdata_q <= 16'h0000;
            mem_rdata_q <= 16'h0000;
            if_rdata_q  <= 16'h0000;
            mem_ready_q <= 1'b0;
            if_ready_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_ready_q <= mem_ready_d;
            if_ready_q  <= if_ready_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign mem_rdata  = mem_rdata_q;
    assign if_rdata   = if_rdata_q;
    assign mem_ready  = mem_ready_q;
    assign if_ready   = if_ready_q;
    assign bus_err    = bus_err_q;
    assign pipe_stall = (data_req_s && !mem_ready_q) || (if_req && !if_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a default-timeout instance and a TIMEOUT_CYCLES=4 instance
// share the same stimulus; expected values are written out cycle by cycle.
module tb_mem_arbiter;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        rst_to    = 1'b1;
    logic        if_req    = 1'b0;
    logic [15:0] if_addr   = 16'h0000;
    logic        mem_read  = 1'b0;
    logic        mem_write = 1'b0;
    logic [15:0] mem_addr  = 16'h0000;
    logic [15:0] mem_wdata = 16'h0000;
    logic [15:0] bus_rdata = 16'h0000;
    logic        bus_ack   = 1'b0;

    logic [15:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic        if_ready, mem_ready, pipe_stall, bus_req, bus_we, bus_err;
    logic [15:0] to_if_rdata, to_mem_rdata, to_bus_addr, to_bus_wdata;
    logic        to_if_ready, to_mem_ready, to_pipe_stall, to_bus_req, to_bus_we, to_bus_err;

    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   acc_cnt  = 0;
    int   acc_base = 0;
    logic req_prev = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pipe_stall(pipe_stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
    );

    mem_arbiter #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst(rst_to),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(to_if_rdata), .if_ready(to_if_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(to_mem_rdata), .mem_ready(to_mem_ready), .pipe_stall(to_pipe_stall),
        .bus_req(to_bus_req), .bus_we(to_bus_we), .bus_addr(to_bus_addr), .bus_wdata(to_bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(to_bus_err)
    );

    // Count bus accesses on the default instance as rising edges of bus_req.
    always @(posedge clk) begin
        req_prev <= bus_req;
        if (bus_req && !req_prev) acc_cnt <= acc_cnt + 1;
    end

    task automatic chk_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) tick();

        chk_val("rst_bus_req",    {15'd0, bus_req},    16'h0000);
        chk_val("rst_bus_we",     {15'd0, bus_we},     16'h0000);
        chk_val("rst_bus_addr",   bus_addr,            16'h0000);
        chk_val("rst_bus_wdata",  bus_wdata,           16'h0000);
        chk_val("rst_mem_rdata",  mem_rdata,           16'h0000);
        chk_val("rst_if_rdata",   if_rdata,            16'h0000);
        chk_val("rst_mem_ready",  {15'd0, mem_ready},  16'h0000);
        chk_val("rst_if_ready",   {15'd0, if_ready},   16'h0000);
        chk_val("rst_bus_err",    {15'd0, bus_err},    16'h0000);
        chk_val("rst_pipe_stall", {15'd0, pipe_stall}, 16'h0000);
        chk_val("rst_to_outs",
                {to_bus_req, to_bus_we, to_mem_ready, to_if_ready, to_bus_err, to_pipe_stall, 10'd0}, 16'h0000);
        chk_val("rst_to_data", to_bus_addr | to_bus_wdata | to_mem_rdata | to_if_rdata, 16'h0000);
        rst = 1'b0;
        tick();

        // Load, zero wait: grant N, bus_req N+1, ack N+1, ready N+2.
        mem_read = 1'b1; mem_addr = 16'h0040;
        #1;
        chk_val("ld_stall_n",   {15'd0, pipe_stall}, 16'h0001);
        chk_val("ld_req_n",     {15'd0, bus_req},    16'h0000);
        tick();
        chk_val("ld_req_n1",    {15'd0, bus_req},    16'h0001);
        chk_val("ld_we_n1",     {15'd0, bus_we},     16'h0000);
        chk_val("ld_addr_n1",   bus_addr,            16'h0040);
        chk_val("ld_stall_n1",  {15'd0, pipe_stall}, 16'h0001);
        chk_val("ld_rdy_n1",    {15'd0, mem_ready},  16'h0000);
        bus_ack = 1'b1; bus_rdata = 16'hBEEF;
        tick();
        chk_val("ld_rdy_n2",    {15'd0, mem_ready},  16'h0001);
        chk_val("ld_rdata_n2",  mem_rdata,           16'hBEEF);
        chk_val("ld_req_n2",    {15'd0, bus_req},    16'h0000);
        chk_val("ld_stall_n2",  {15'd0, pipe_stall}, 16'h0000);
        mem_read = 1'b0; bus_ack = 1'b0;
        tick();
        chk_val("ld_rdy_n3",    {15'd0, mem_ready},  16'h0000);
        chk_val("ld_req_n3",    {15'd0, bus_req},    16'h0000);

        // Store with three wait cycles before bus_ack.
        mem_write = 1'b1; mem_addr = 16'h0010; mem_wdata = 16'h1234; bus_rdata = 16'h5A5A;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk_val($sformatf("st_req_w%0d", i),   {15'd0, bus_req},   16'h0001);
            chk_val($sformatf("st_we_w%0d", i),    {15'd0, bus_we},    16'h0001);
            chk_val($sformatf("st_addr_w%0d", i),  bus_addr,           16'h0010);
            chk_val($sformatf("st_wdata_w%0d", i), bus_wdata,          16'h1234);
            chk_val($sformatf("st_rdy_w%0d", i),   {15'd0, mem_ready}, 16'h0000);
            if (i == 3) bus_ack = 1'b1;
            tick();
        end
        chk_val("st_rdy",       {15'd0, mem_ready}, 16'h0001);
        chk_val("st_req_drop",  {15'd0, bus_req},   16'h0000);
        chk_val("st_rdata_kept", mem_rdata,         16'hBEEF);
        mem_write = 1'b0; bus_ack = 1'b0;
        tick();
        chk_val("st_rdy_single", {15'd0, mem_ready}, 16'h0000);

        // Simultaneous fetch and load: data first, then fetch.
        acc_base = acc_cnt;
        if_req = 1'b1; if_addr = 16'h0100; mem_read = 1'b1; mem_addr = 16'h0050;
        tick();
        chk_val("tie_addr_data", bus_addr,          16'h0050);
        chk_val("tie_we_data",   {15'd0, bus_we},   16'h0000);
        bus_ack = 1'b1; bus_rdata = 16'h1111;
        tick();
        chk_val("tie_mem_rdy",   {15'd0, mem_ready},  16'h0001);
        chk_val("tie_mem_rdata", mem_rdata,           16'h1111);
        chk_val("tie_if_rdy0",   {15'd0, if_ready},   16'h0000);
        chk_val("tie_stall",     {15'd0, pipe_stall}, 16'h0001);
        mem_read = 1'b0; bus_ack = 1'b0;
        tick();
        chk_val("tie_req_inst",  {15'd0, bus_req},  16'h0001);
        chk_val("tie_addr_inst", bus_addr,          16'h0100);
        bus_ack = 1'b1; bus_rdata = 16'h2222;
        tick();
        chk_val("tie_if_rdy",    {15'd0, if_ready},  16'h0001);
        chk_val("tie_if_rdata",  if_rdata,           16'h2222);
        chk_val("tie_mem_rdy0",  {15'd0, mem_ready}, 16'h0000);
        chk_val("tie_rdata_hold", mem_rdata,         16'h1111);
        if_req = 1'b0; bus_ack = 1'b0;
        tick();
        chk_val("tie_idle",      {15'd0, bus_req},   16'h0000);
        chk_val("tie_accesses",  16'(acc_cnt - acc_base), 16'h0002);

        // Load arriving during a fetch that waits four cycles.
        if_req = 1'b1; if_addr = 16'h0200;
        tick();
        mem_read = 1'b1; mem_addr = 16'h0060;
        for (int i = 0; i < 4; i++) begin
            chk_val($sformatf("np_addr_w%0d", i), bus_addr,           16'h0200);
            chk_val($sformatf("np_rdy_w%0d", i),  {15'd0, mem_ready}, 16'h0000);
            tick();
        end
        bus_ack = 1'b1; bus_rdata = 16'h3333;
        tick();
        chk_val("np_if_rdy",    {15'd0, if_ready},  16'h0001);
        chk_val("np_if_rdata",  if_rdata,           16'h3333);
        chk_val("np_mem_rdy0",  {15'd0, mem_ready}, 16'h0000);
        if_req = 1'b0; bus_ack = 1'b0;
        tick();
        chk_val("np_req_data",  {15'd0, bus_req},   16'h0001);
        chk_val("np_addr_data", bus_addr,           16'h0060);
        bus_ack = 1'b1; bus_rdata = 16'h4444;
        tick();
        chk_val("np_mem_rdy",   {15'd0, mem_ready}, 16'h0001);
        chk_val("np_mem_rdata", mem_rdata,          16'h4444);
        mem_read = 1'b0; bus_ack = 1'b0;
        tick();

        // Timeout instance: one good load, then a load that is never acknowledged.
        rst_to = 1'b0;
        tick();
        mem_read = 1'b1; mem_addr = 16'h0070;
        tick();
        chk_val("to_pre_req",   {15'd0, to_bus_req}, 16'h0001);
        bus_ack = 1'b1; bus_rdata = 16'h5555;
        tick();
        chk_val("to_pre_rdy",   {15'd0, to_mem_ready}, 16'h0001);
        chk_val("to_pre_rdata", to_mem_rdata,          16'h5555);
        mem_read = 1'b0; bus_ack = 1'b0;
        tick();
        mem_read = 1'b1; mem_addr = 16'h0072; bus_rdata = 16'hFFFF;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk_val($sformatf("to_req_w%0d", i), {15'd0, to_bus_req},   16'h0001);
            chk_val($sformatf("to_rdy_w%0d", i), {15'd0, to_mem_ready}, 16'h0000);
            chk_val($sformatf("to_err_w%0d", i), {15'd0, to_bus_err},   16'h0000);
            tick();
        end
        chk_val("to_rdy",       {15'd0, to_mem_ready}, 16'h0001);
        chk_val("to_rdata0",    to_mem_rdata,          16'h0000);
        chk_val("to_err_set",   {15'd0, to_bus_err},   16'h0001);
        chk_val("to_req_drop",  {15'd0, to_bus_req},   16'h0000);
        chk_val("main_waiting", {15'd0, bus_req},      16'h0001);
        chk_val("main_no_rdy",  {15'd0, mem_ready},    16'h0000);
        mem_read = 1'b0;
        tick();
        chk_val("to_rdy_single", {15'd0, to_mem_ready}, 16'h0000);
        chk_val("to_err_sticky", {15'd0, to_bus_err},   16'h0001);

        // Reset while the default instance waits on its load.
        rst = 1'b1;
        #1;
        chk_val("mid_rst_req",  {15'd0, bus_req},   16'h0000);
        tick();
        chk_val("mid_rst_rdy",  {15'd0, mem_ready}, 16'h0000);
        rst = 1'b0;
        tick();
        chk_val("post_rst_rdy",   {15'd0, mem_ready}, 16'h0000);
        chk_val("post_rst_req",   {15'd0, bus_req},   16'h0000);
        chk_val("post_rst_rdata", mem_rdata,          16'h0000);
        mem_read = 1'b1; mem_addr = 16'h0080;
        tick();
        chk_val("post_req",   {15'd0, bus_req}, 16'h0001);
        chk_val("post_addr",  bus_addr,         16'h0080);
        bus_ack = 1'b1; bus_rdata = 16'h6666;
        tick();
        chk_val("post_rdy",   {15'd0, mem_ready},  16'h0001);
        chk_val("post_rdata", mem_rdata,           16'h6666);
        chk_val("to_err_after_ok", {15'd0, to_bus_err}, 16'h0001);
        mem_read = 1'b0; bus_ack = 1'b0;
        tick();
        chk_val("post_rdy_end", {15'd0, mem_ready}, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the number of cycles a bus access may wait for bus_ack before it is aborted (range 1..255).
REQ-002 clk  in  1  the single clock; all state SHALL be updated on its rising edge.
REQ-003 rst  in  1  the reset; it SHALL be asynchronous and active-high.
REQ-004 if_req  in  1  instruction-fetch request, held until if_ready.
REQ-005 if_addr  in  16  fetch word address.
REQ-006 if_rdata  out  16  fetched instruction, valid while if_ready=1.
REQ-007 if_ready  out  1  one-cycle pulse marking fetch completion.
REQ-008 mem_read  in  1  data load request from the EX/MEM stage.
REQ-009 mem_write  in  1  data store request from the EX/MEM stage.
REQ-010 mem_addr  in  16  data address (EX/MEM ALU result).
REQ-011 mem_wdata  in  16  store data.
REQ-012 mem_rdata  out  16  load data, valid while mem_ready=1.
REQ-013 mem_ready  out  1  one-cycle pulse marking data-access completion.
REQ-014 pipe_stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM registers.
REQ-015 bus_req, bus_we  out  1 each  single-port memory request and write-enable.
REQ-016 bus_addr, bus_wdata  out  16 each  memory address and write data.
REQ-017 bus_rdata  in  16  memory read data; bus_ack  in  1  access-complete strobe.
REQ-018 bus_err  out  1  sticky timeout flag.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, DATA, INST.
REQ-020 In IDLE, when mem_read|mem_write=1 and mem_ready=0, the FSM SHALL go to DATA and latch mem_addr, mem_wdata and bus_we=mem_write.
REQ-021 In IDLE, when there is no data request and if_req=1 and if_ready=0, the FSM SHALL go to INST and latch if_addr, with bus_we=0.
REQ-022 A simultaneous data request and fetch request in IDLE SHALL be granted to data.
REQ-023 An access in progress SHALL never be pre-empted; a data request arriving during INST waits for INST to complete.
REQ-024 bus_req, bus_we, bus_addr and bus_wdata SHALL be registered outputs, asserted from the cycle after the grant, and held stable until the cycle after bus_ack.
REQ-025 On bus_ack=1 in DATA, the block SHALL capture bus_rdata into mem_rdata, pulse mem_ready in the next cycle, drop bus_req and return to IDLE.
REQ-026 The INST completion path SHALL behave as REQ-025, using if_rdata and if_ready.
REQ-027 Minimum latency SHALL be: request at cycle N, bus_req at N+1, bus_ack at N+1, ready pulse at N+2.
REQ-028 A request SHALL NOT be re-accepted in a cycle in which its own ready pulse is high, so each request produces exactly one bus access.
REQ-029 pipe_stall SHALL be combinational: (mem_read|mem_write)&~mem_ready | if_req&~if_ready.
REQ-030 A wait counter SHALL clear on each grant and increment every cycle in DATA or INST while bus_ack=0.
REQ-031 When the wait counter reaches TIMEOUT_CYCLES, the block SHALL drop bus_req, pulse the pending ready with rdata=16'h0000, set bus_err and return to IDLE.
REQ-032 bus_err SHALL remain set until reset.
REQ-033 bus_ack received in IDLE SHALL be ignored.
REQ-034 A write access SHALL leave mem_rdata unchanged.

Reset
REQ-035 While rst=1, the block SHALL immediately hold state=IDLE and wait counter=0.
REQ-036 While rst=1, all registered outputs SHALL be 0: bus_req, bus_we, bus_addr, bus_wdata, mem_rdata, if_rdata, mem_ready, if_ready, bus_err.
REQ-037 Reset asserted mid-access SHALL abandon the access with no ready pulse.

Structure
REQ-038 The state encodings (IDLE=2'd0, DATA=2'd1, INST=2'd2) and the TIMEOUT_CYCLES default SHALL reside in the shared defines file.
REQ-039 The wait counter and its compare logic SHALL be a sub-module, mem_arb_timeout, with inputs clear, count_en and outputs expired, 8-bit count.

Verification
REQ-040 Stimulus: load with mem_read=1, mem_addr=16'h0040, bus_ack 1 cycle after bus_req, bus_rdata=16'hBEEF. Required response: mem_ready at N+2 with mem_rdata=16'hBEEF, and pipe_stall high for N..N+1.
REQ-041 Stimulus: store with mem_write=1, mem_addr=16'h0010, mem_wdata=16'h1234, bus_ack after 3 wait cycles. Required response: bus_we=1, bus_addr and bus_wdata stable throughout, and a single mem_ready pulse.
REQ-042 Stimulus: if_req and mem_read asserted in the same cycle. Required response: the data access occurs first, then the fetch, with two bus accesses total.
REQ-043 Stimulus: mem_read arrives during an INST access waiting 4 cycles. Required response: INST completes first, then DATA.
REQ-044 Stimulus: TIMEOUT_CYCLES=4 and bus_ack never asserted. Required response: mem_ready pulses with rdata=0 after 4 wait cycles, bus_err=1 and stays set.
REQ-045 Stimulus: rst pulsed during DATA wait. Required response: bus_req=0 immediately, no mem_ready, and the next request is serviced normally.
